// File: rtl/e203_ifu_fetch_seq.sv
// e203_ifu_fetch_seq: single-outstanding instruction fetch sequencer with a one-entry IR
// and static next-PC prediction (JAL and backward branches taken).
module e203_ifu_fetch_seq #(
  parameter int PC_SIZE = 32,
  parameter logic [PC_SIZE-1:0] RESET_PC = PC_SIZE'(32'h8000_0000)
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               ifu_req_valid,
  input  logic               ifu_req_ready,
  output logic [PC_SIZE-1:0] ifu_req_pc,
  input  logic               ifu_rsp_valid,
  output logic               ifu_rsp_ready,
  input  logic [31:0]        ifu_rsp_instr,
  input  logic               ifu_rsp_err,
  output logic [31:0]        mdec_instr,
  input  logic               dec_rv32,
  input  logic               dec_jal,
  input  logic               dec_jalr,
  input  logic               dec_bxx,
  input  logic [31:0]        dec_bjp_imm,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic [31:0]        ir_instr,
  output logic [PC_SIZE-1:0] ir_pc,
  output logic               ir_pred_taken,
  output logic               ir_err,
  input  logic               flush_req,
  input  logic [PC_SIZE-1:0] flush_pc,
  output logic               flush_ack
);
  typedef enum logic [1:0] {REQ, WAIT, STALL, DRAIN} state_e;
  state_e state_q, state_d;
  logic [PC_SIZE-1:0] req_pc_q, req_pc_d, ir_pc_q, ir_pc_d, seq_pc, tgt_pc;
  logic [31:0] ir_instr_q, ir_instr_d;
  logic ir_valid_q, ir_valid_d, ir_err_q, ir_err_d, ir_pred_q, ir_pred_d;
  logic req_hs, rsp_hs, rsp_take, stop, pred, outstanding;
  assign ifu_req_valid = state_q == REQ;
  assign ifu_req_pc    = req_pc_q;
  assign ifu_rsp_ready = state_q == DRAIN | (state_q == WAIT & (!ir_valid_q | ir_ready));
  assign mdec_instr    = ifu_rsp_instr;
  assign flush_ack     = flush_req;
  assign ir_valid      = ir_valid_q;
  assign ir_instr      = ir_instr_q;
  assign ir_pc         = ir_pc_q;
  assign ir_pred_taken = ir_pred_q;
  assign ir_err        = ir_err_q;
  assign req_hs   = ifu_req_valid & ifu_req_ready;
  assign rsp_hs   = ifu_rsp_valid & ifu_rsp_ready;
  assign rsp_take = rsp_hs & state_q == WAIT & !flush_req;
  assign stop     = ifu_rsp_err | dec_jalr;
  assign pred     = !stop & (dec_jal | (dec_bxx & dec_bjp_imm[31]));
  assign seq_pc   = req_pc_q + (dec_rv32 ? PC_SIZE'(4) : PC_SIZE'(2));
  assign tgt_pc   = req_pc_q + dec_bjp_imm[PC_SIZE-1:0];
  // A request stays in flight past a flush if it was accepted but its response has not arrived yet.
  assign outstanding = ((state_q == WAIT | state_q == DRAIN) & !rsp_hs) | (state_q == REQ & req_hs);
  always_comb begin
    state_d    = state_q;
    req_pc_d   = req_pc_q;
    ir_valid_d = ir_valid_q & !ir_ready;
    ir_instr_d = ir_instr_q;
    ir_pc_d    = ir_pc_q;
    ir_err_d   = ir_err_q;
    ir_pred_d  = ir_pred_q;
    if (flush_req) begin
      ir_valid_d = 1'b0;
      req_pc_d   = flush_pc;
      state_d    = outstanding ? DRAIN : REQ;
    end else if (rsp_take) begin
      ir_valid_d = 1'b1;
      ir_instr_d = ifu_rsp_instr;
      ir_pc_d    = req_pc_q;
      ir_err_d   = ifu_rsp_err;
      ir_pred_d  = pred;
      req_pc_d   = stop ? req_pc_q : pred ? tgt_pc : seq_pc;
      state_d    = stop ? STALL : REQ;
    end else if (state_q == REQ & req_hs) begin
      state_d = WAIT;
    end else if (state_q == DRAIN & rsp_hs) begin
      state_d = REQ;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= REQ;
      req_pc_q   <= RESET_PC;
      ir_valid_q <= 1'b0;
      ir_instr_q <= '0;
      ir_pc_q    <= '0;
      ir_err_q   <= 1'b0;
      ir_pred_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_pc_q   <= req_pc_d;
      ir_valid_q <= ir_valid_d;
      ir_instr_q <= ir_instr_d;
      ir_pc_q    <= ir_pc_d;
      ir_err_q   <= ir_err_d;
      ir_pred_q  <= ir_pred_d;
    end
  end
endmodule

// File: tb/tb_e203_ifu_fetch_seq.sv
// tb_e203_ifu_fetch_seq: table of fetch transactions plus hand-written flush, stall,
// backpressure, wrap and reset sequences for the fetch sequencer.
module tb_e203_ifu_fetch_seq;
  logic clk = 1'b0, rst_n = 1'b0;
  logic ifu_req_valid, ifu_req_ready = 1'b0;
  logic [31:0] ifu_req_pc;
  logic ifu_rsp_valid = 1'b0, ifu_rsp_ready, ifu_rsp_err = 1'b0;
  logic [31:0] ifu_rsp_instr = '0, mdec_instr, dec_bjp_imm = '0;
  logic dec_rv32 = 1'b0, dec_jal = 1'b0, dec_jalr = 1'b0, dec_bxx = 1'b0;
  logic ir_valid, ir_ready = 1'b1, ir_pred_taken, ir_err;
  logic [31:0] ir_instr, ir_pc;
  logic flush_req = 1'b0, flush_ack;
  logic [31:0] flush_pc = '0;
  int nvec = 0, nerr = 0;

  typedef struct {
    logic [31:0] pc, instr, imm;
    logic rv32, jal, jalr, bxx, err, pred, stop;
  } vec_t;
  typedef struct {
    logic [31:0] instr, pc;
    logic pred, err;
  } ir_t;
  logic [31:0] exp_pc_q[$];
  ir_t exp_ir_q[$];
  vec_t vt[12];

  e203_ifu_fetch_seq dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_pc(ifu_req_pc),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
    .ifu_rsp_instr(ifu_rsp_instr), .ifu_rsp_err(ifu_rsp_err),
    .mdec_instr(mdec_instr), .dec_rv32(dec_rv32), .dec_jal(dec_jal), .dec_jalr(dec_jalr),
    .dec_bxx(dec_bxx), .dec_bjp_imm(dec_bjp_imm),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_instr(ir_instr), .ir_pc(ir_pc),
    .ir_pred_taken(ir_pred_taken), .ir_err(ir_err),
    .flush_req(flush_req), .flush_pc(flush_pc), .flush_ack(flush_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic vec_t mk(input logic [31:0] pc, instr, imm,
                              input logic rv32, jal, jalr, bxx, err, pred, stop);
    vec_t v;
    v.pc = pc; v.instr = instr; v.imm = imm; v.rv32 = rv32; v.jal = jal; v.jalr = jalr;
    v.bxx = bxx; v.err = err; v.pred = pred; v.stop = stop;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive_dec(input vec_t v, input logic on);
    ifu_rsp_valid = on;
    ifu_rsp_instr = on ? v.instr : 32'h0;
    ifu_rsp_err   = on & v.err;
    dec_rv32      = on & v.rv32;
    dec_jal       = on & v.jal;
    dec_jalr      = on & v.jalr;
    dec_bxx       = on & v.bxx;
    dec_bjp_imm   = on ? v.imm : 32'h0;
  endtask

  // One complete fetch: wait for the request, accept it, respond after dly cycles, check the IR.
  task automatic fetch(input vec_t v, input int dly);
    int n;
    ir_t e;
    exp_pc_q.push_back(v.pc);
    n = 0;
    while (!ifu_req_valid && n < 20) begin
      step();
      n++;
    end
    chkb("req_valid", ifu_req_valid, 1'b1);
    chk("req_pc", ifu_req_pc, exp_pc_q.pop_front());
    ifu_req_ready = 1'b1;
    step();
    ifu_req_ready = 1'b0;
    repeat (dly) step();
    drive_dec(v, 1'b1);
    e.instr = v.instr; e.pc = v.pc; e.pred = v.pred; e.err = v.err;
    exp_ir_q.push_back(e);
    #1;
    chk("mdec_instr", mdec_instr, v.instr);
    chkb("rsp_ready", ifu_rsp_ready, 1'b1);
    step();
    drive_dec(v, 1'b0);
    e = exp_ir_q.pop_front();
    chkb("ir_valid", ir_valid, 1'b1);
    chk("ir_instr", ir_instr, e.instr);
    chk("ir_pc", ir_pc, e.pc);
    chkb("ir_pred", ir_pred_taken, e.pred);
    chkb("ir_err", ir_err, e.err);
    chkb(v.stop ? "stop_noreq" : "next_req", ifu_req_valid, !v.stop);
  endtask

  initial begin
    vec_t v;
    vt[0]  = mk(32'h8000_0000, 32'h0000_0013, 32'h0,         1, 0, 0, 0, 0, 0, 0);
    vt[1]  = mk(32'h8000_0004, 32'h0010_0093, 32'h0,         1, 0, 0, 0, 0, 0, 0);
    vt[2]  = mk(32'h8000_0008, 32'h0000_4501, 32'h0,         0, 0, 0, 0, 0, 0, 0);
    vt[3]  = mk(32'h8000_000A, 32'h0000_0505, 32'h0,         0, 0, 0, 0, 0, 0, 0);
    vt[4]  = mk(32'h8000_000C, 32'h0020_0113, 32'h0,         1, 0, 0, 0, 0, 0, 0);
    vt[5]  = mk(32'h8000_0010, 32'h1000_006F, 32'h0000_0100, 1, 1, 0, 0, 0, 1, 0);
    vt[6]  = mk(32'h8000_0110, 32'hF11F_F06F, 32'hFFFF_FF10, 1, 1, 0, 0, 0, 1, 0);
    vt[7]  = mk(32'h8000_0020, 32'hFE00_0CE3, 32'hFFFF_FFF8, 1, 0, 0, 1, 0, 1, 0);
    vt[8]  = mk(32'h8000_0018, 32'h0030_0193, 32'h0,         1, 0, 0, 0, 0, 0, 0);
    vt[9]  = mk(32'h8000_001C, 32'h0040_0213, 32'h0,         1, 0, 0, 0, 0, 0, 0);
    vt[10] = mk(32'h8000_0020, 32'h0000_0463, 32'h0000_0008, 1, 0, 0, 1, 0, 0, 0);
    vt[11] = mk(32'h8000_0024, 32'h0000_8067, 32'h0000_0040, 1, 1, 1, 0, 0, 0, 1);
    repeat (2) step();
    chkb("rst_ir_valid", ir_valid, 1'b0);
    chk("rst_req_pc", ifu_req_pc, 32'h8000_0000);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 12; i++) fetch(vt[i], i % 3);
    // JALR stall: IR held, no requests until flush
    ir_ready = 1'b0;
    repeat (4) begin
      step();
      chkb("jalr_noreq", ifu_req_valid, 1'b0);
    end
    chk("jalr_ir_hold", ir_pc, 32'h8000_0024);
    flush_req = 1'b1; flush_pc = 32'h8000_0200;
    #1 chkb("flush_ack", flush_ack, 1'b1);
    step();
    flush_req = 1'b0; ir_ready = 1'b1;
    chkb("flush_ir_inv", ir_valid, 1'b0);
    chkb("flush_req_valid", ifu_req_valid, 1'b1);
    chk("flush_req_pc", ifu_req_pc, 32'h8000_0200);
    // flush while WAIT: stale response is drained
    ifu_req_ready = 1'b1;
    step();
    ifu_req_ready = 1'b0;
    flush_req = 1'b1; flush_pc = 32'h8000_0400;
    #1 chkb("wait_flush_ack", flush_ack, 1'b1);
    step();
    flush_req = 1'b0;
    chkb("drain_noreq0", ifu_req_valid, 1'b0);
    step();
    chkb("drain_noreq1", ifu_req_valid, 1'b0);
    v = mk(32'h0, 32'hDEAD_BEEF, 32'h0000_0100, 1, 1, 0, 0, 0, 0, 0);
    drive_dec(v, 1'b1);
    #1 chkb("drain_rsp_ready", ifu_rsp_ready, 1'b1);
    step();
    drive_dec(v, 1'b0);
    chkb("drain_ir_valid", ir_valid, 1'b0);
    chkb("drain_req_valid", ifu_req_valid, 1'b1);
    chk("drain_req_pc", ifu_req_pc, 32'h8000_0400);
    // bus error wins over JAL, stalls until flush
    fetch(mk(32'h8000_0400, 32'h0400_006F, 32'h0000_0040, 1, 1, 0, 0, 1, 0, 1), 1);
    ir_ready = 1'b0;
    repeat (3) begin
      step();
      chkb("err_noreq", ifu_req_valid, 1'b0);
    end
    chkb("err_hold", ir_err, 1'b1);
    flush_req = 1'b1; flush_pc = 32'h8000_0500;
    step();
    flush_req = 1'b0; ir_ready = 1'b1;
    // backpressure: IR full and not consumed holds off the response
    fetch(mk(32'h8000_0500, 32'h0050_0293, 32'h0, 1, 0, 0, 0, 0, 0, 0), 0);
    ir_ready = 1'b0;
    chk("bp_req_pc", ifu_req_pc, 32'h8000_0504);
    ifu_req_ready = 1'b1;
    step();
    ifu_req_ready = 1'b0;
    v = mk(32'h0, 32'h0060_0313, 32'h0, 1, 0, 0, 0, 0, 0, 0);
    drive_dec(v, 1'b1);
    repeat (5) begin
      #1 chkb("bp_rsp_ready", ifu_rsp_ready, 1'b0);
      step();
      chk("bp_ir_instr", ir_instr, 32'h0050_0293);
      chk("bp_ir_pc", ir_pc, 32'h8000_0500);
    end
    ir_ready = 1'b1;
    #1 chkb("bp_release", ifu_rsp_ready, 1'b1);
    step();
    drive_dec(v, 1'b0);
    chk("bp_ir_new", ir_instr, 32'h0060_0313);
    chk("bp_ir_new_pc", ir_pc, 32'h8000_0504);
    chk("bp_next_pc", ifu_req_pc, 32'h8000_0508);
    // flush in REQ without handshake, then PC wraps modulo 2^32
    flush_req = 1'b1; flush_pc = 32'hFFFF_FFFC;
    step();
    flush_req = 1'b0;
    fetch(mk(32'hFFFF_FFFC, 32'h0070_0393, 32'h0, 1, 0, 0, 0, 0, 0, 0), 0);
    ir_ready = 1'b0;
    chk("wrap_pc", ifu_req_pc, 32'h0000_0000);
    // reset during WAIT clears everything at once
    ifu_req_ready = 1'b1;
    step();
    ifu_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chkb("mrst_ir_valid", ir_valid, 1'b0);
    chk("mrst_ir_instr", ir_instr, 32'h0);
    chk("mrst_ir_pc", ir_pc, 32'h0);
    chk("mrst_req_pc", ifu_req_pc, 32'h8000_0000);
    chkb("mrst_rsp_ready", ifu_rsp_ready, 1'b0);
    repeat (2) step();
    rst_n = 1'b1;
    ir_ready = 1'b1;
    step();
    chkb("restart_valid", ifu_req_valid, 1'b1);
    chk("restart_pc", ifu_req_pc, 32'h8000_0000);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
